enemy_tiro_ctrl: RTL and testbench

ENEMY_TIRO_CTRL -- requirements
Module: enemy_tiro_ctrl

---
 rtl/enemy_tiro_ctrl_pkg.sv | 30 +++
 rtl/enemy_tiro_ctrl_tiro_slot.sv | 54 +++++
 rtl/enemy_tiro_ctrl.sv | 143 ++++++++++++++
 tb/tb_enemy_tiro_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_tiro_ctrl_pkg.sv
// Shared geometry, sizing and player-state encoding for the enemy projectile controller.
package enemy_tiro_ctrl_pkg;

    localparam int N_ENEMY   = 25;
    localparam int N_TIRO    = 4;
    localparam int VEL       = 4;
    localparam int SCREEN_H  = 480;
    localparam int PLAYER_Y  = 440;
    localparam int PLAYER_W  = 32;
    localparam int PLAYER_H  = 16;
    localparam int ESP_X     = 40;
    localparam int ESP_Y     = 32;
    localparam int ENEMY_W   = 32;
    localparam int ENEMY_H   = 24;
    localparam int FORM_COLS = 5;
    localparam int COORD_W   = 10;

    typedef enum logic {
        VIVO  = 1'b0,
        MORTO = 1'b1
    } state_t;

    // Formation pixel of a given column/row, truncated to screen coordinate width.
    function automatic logic [COORD_W-1:0] spawn_pos(input logic [COORD_W-1:0] base,
                                                     input int idx, input int pitch,
                                                     input int offset);
        return COORD_W'(int'(base) + idx * pitch + offset);
    endfunction

endpackage

// File: rtl/enemy_tiro_ctrl_tiro_slot.sv
// One enemy projectile: holds position, falls by VEL per tick, frees off-screen or on player contact.
module tiro_slot #(
    parameter int VEL      = 4,
    parameter int SCREEN_H = 480,
    parameter int PLAYER_Y = 440,
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic [9:0] player_x,
    output logic       ativo,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hit
);

    logic [10:0] y_next;
    logic [10:0] px_end;
    logic        off_screen;
    logic        in_row;
    logic        in_col;

    // Compares run one bit wider so player_x + PLAYER_W never wraps.
    assign y_next     = {1'b0, y} + 11'(VEL);
    assign px_end     = {1'b0, player_x} + 11'(PLAYER_W);
    assign off_screen = y_next >= 11'(SCREEN_H);
    assign in_row     = (y_next >= 11'(PLAYER_Y)) && (y_next < 11'(PLAYER_Y + PLAYER_H));
    assign in_col     = ({1'b0, x} >= {1'b0, player_x}) && ({1'b0, x} < px_end);
    assign hit        = tick && ativo && !off_screen && in_row && in_col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ativo <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else if (clear) begin
            ativo <= 1'b0;
        end else if (load) begin
            ativo <= 1'b1;
            x     <= load_x;
            y     <= load_y;
        end else if (tick && ativo) begin
            if (off_screen || hit) ativo <= 1'b0;
            else                   y     <= y_next[9:0];
        end
    end

endmodule

// File: rtl/enemy_tiro_ctrl.sv
// Enemy projectile controller: edge-detected fire requests, slot allocation and player life FSM.
module enemy_tiro_ctrl #(
    parameter int N_ENEMY  = enemy_tiro_ctrl_pkg::N_ENEMY,
    parameter int N_TIRO   = enemy_tiro_ctrl_pkg::N_TIRO,
    parameter int VEL      = enemy_tiro_ctrl_pkg::VEL,
    parameter int SCREEN_H = enemy_tiro_ctrl_pkg::SCREEN_H,
    parameter int PLAYER_Y = enemy_tiro_ctrl_pkg::PLAYER_Y,
    parameter int PLAYER_W = enemy_tiro_ctrl_pkg::PLAYER_W,
    parameter int PLAYER_H = enemy_tiro_ctrl_pkg::PLAYER_H,
    parameter int ESP_X    = enemy_tiro_ctrl_pkg::ESP_X,
    parameter int ESP_Y    = enemy_tiro_ctrl_pkg::ESP_Y,
    parameter int ENEMY_W  = enemy_tiro_ctrl_pkg::ENEMY_W,
    parameter int ENEMY_H  = enemy_tiro_ctrl_pkg::ENEMY_H
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  tick,
    input  logic [N_ENEMY-1:0]    ID_enemy_tiro,
    input  logic [N_ENEMY-1:0]    enemy_vivos,
    input  logic [9:0]            formacao_x,
    input  logic [9:0]            formacao_y,
    input  logic [9:0]            player_x,
    output logic [N_TIRO-1:0]     tiro_ativo,
    output logic [10*N_TIRO-1:0]  tiro_x,
    output logic [10*N_TIRO-1:0]  tiro_y,
    output logic                  jogador_vivo,
    output logic                  hit,
    output logic [7:0]            tiros_perdidos
);

    import enemy_tiro_ctrl_pkg::state_t;
    import enemy_tiro_ctrl_pkg::VIVO;
    import enemy_tiro_ctrl_pkg::MORTO;
    import enemy_tiro_ctrl_pkg::FORM_COLS;
    import enemy_tiro_ctrl_pkg::spawn_pos;

    state_t             state;
    logic [N_ENEMY-1:0] id_prev;
    logic [N_ENEMY-1:0] req;
    logic               req_any;
    int                 req_idx;
    logic               free_any;
    int                 free_idx;
    logic [9:0]         spawn_x;
    logic [9:0]         spawn_y;
    logic [N_TIRO-1:0]  slot_hit;
    logic [N_TIRO-1:0]  slot_load;
    logic               any_hit;
    logic               alive;
    logic               spawn;
    logic               clear_all;
    logic               slot_tick;

    assign alive     = (state == VIVO);
    assign req       = ID_enemy_tiro & ~id_prev & enemy_vivos;
    assign any_hit   = |slot_hit;
    assign clear_all = restart || (alive && any_hit);
    assign slot_tick = tick && alive && !restart;
    assign spawn     = !restart && alive && !any_hit && req_any && free_any;

    // Lowest-index new request wins; free slots are judged on pre-tick occupancy only.
    always_comb begin
        req_any  = 1'b0;
        req_idx  = 0;
        free_any = 1'b0;
        free_idx = 0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (req[i]) begin
                req_any = 1'b1;
                req_idx = i;
            end
        end
        for (int k = N_TIRO - 1; k >= 0; k--) begin
            if (!tiro_ativo[k]) begin
                free_any = 1'b1;
                free_idx = k;
            end
        end
    end

    assign spawn_x = spawn_pos(formacao_x, req_idx % FORM_COLS, ESP_X, ENEMY_W / 2);
    assign spawn_y = spawn_pos(formacao_y, req_idx / FORM_COLS, ESP_Y, ENEMY_H);

    for (genvar k = 0; k < N_TIRO; k++) begin : g_slot
        assign slot_load[k] = spawn && (free_idx == k);

        tiro_slot #(
            .VEL      (VEL),
            .SCREEN_H (SCREEN_H),
            .PLAYER_Y (PLAYER_Y),
            .PLAYER_W (PLAYER_W),
            .PLAYER_H (PLAYER_H)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear_all),
            .tick     (slot_tick),
            .load     (slot_load[k]),
            .load_x   (spawn_x),
            .load_y   (spawn_y),
            .player_x (player_x),
            .ativo    (tiro_ativo[k]),
            .x        (tiro_x[10*k +: 10]),
            .y        (tiro_y[10*k +: 10]),
            .hit      (slot_hit[k])
        );
    end

    // Player FSM, edge register and drop counter; restart overrides every event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= VIVO;
            jogador_vivo   <= 1'b1;
            hit            <= 1'b0;
            tiros_perdidos <= '0;
            id_prev        <= '0;
        end else begin
            id_prev <= ID_enemy_tiro;
            hit     <= 1'b0;
            if (restart) begin
                state          <= VIVO;
                jogador_vivo   <= 1'b1;
                tiros_perdidos <= '0;
            end else begin
                case (state)
                    VIVO: begin
                        if (any_hit) begin
                            state        <= MORTO;
                            jogador_vivo <= 1'b0;
                            hit          <= 1'b1;
                        end else if (req_any && !free_any && tiros_perdidos != 8'hFF) begin
                            tiros_perdidos <= tiros_perdidos + 8'd1;
                        end
                    end
                    MORTO: state <= MORTO;
                    default: state <= VIVO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_tiro_ctrl.sv
// Scoreboard bench for enemy_tiro_ctrl: expected spawns queued at stimulus, popped when a slot turns on.
module tb_enemy_tiro_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic        tick;
    logic [24:0] ID_enemy_tiro;
    logic [24:0] enemy_vivos;
    logic [9:0]  formacao_x;
    logic [9:0]  formacao_y;
    logic [9:0]  player_x;
    logic [3:0]  tiro_ativo;
    logic [39:0] tiro_x;
    logic [39:0] tiro_y;
    logic        jogador_vivo;
    logic        hit;
    logic [7:0]  tiros_perdidos;

    typedef struct {
        int slot;
        int x;
        int y;
    } shot_t;

    shot_t      sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] ativo_last = '0;

    enemy_tiro_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .restart        (restart),
        .tick           (tick),
        .ID_enemy_tiro  (ID_enemy_tiro),
        .enemy_vivos    (enemy_vivos),
        .formacao_x     (formacao_x),
        .formacao_y     (formacao_y),
        .player_x       (player_x),
        .tiro_ativo     (tiro_ativo),
        .tiro_x         (tiro_x),
        .tiro_y         (tiro_y),
        .jogador_vivo   (jogador_vivo),
        .hit            (hit),
        .tiros_perdidos (tiros_perdidos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_spawn(input int slot, input int x, input int y);
        shot_t s;
        s.slot = slot;
        s.x    = x;
        s.y    = y;
        sb.push_back(s);
    endtask

    task automatic pulse(input int b);
        ID_enemy_tiro[b] = 1'b1;
        step();
        ID_enemy_tiro[b] = 1'b0;
        step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // A slot turning on must match the oldest queued spawn.
    always @(negedge clk) begin : monitor
        shot_t e;
        if (reset === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (tiro_ativo[k] && !ativo_last[k]) begin
                    if (sb.size() > 0) e = sb.pop_front();
                    else               e = '{-1, -1, -1};
                    check("spawn_slot", k, e.slot);
                    check("spawn_x", 32'(tiro_x[10*k +: 10]), e.x);
                    check("spawn_y", 32'(tiro_y[10*k +: 10]), e.y);
                end
            end
        end
        ativo_last = tiro_ativo;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b0;
        restart       = 1'b0;
        tick          = 1'b0;
        ID_enemy_tiro = '0;
        enemy_vivos   = '1;
        formacao_x    = 10'd100;
        formacao_y    = 10'd50;
        player_x      = 10'd0;
        step(3);
        check("rst_ativo", tiro_ativo, 0);
        check("rst_x", tiro_x, 0);
        check("rst_y", tiro_y, 0);
        check("rst_vivo", jogador_vivo, 1);
        check("rst_hit", hit, 0);
        check("rst_perdidos", tiros_perdidos, 0);
        reset = 1'b1;
        step();
        do_tick();
        check("first_tick", tiro_ativo, 0);

        // enemy 7 -> col 2, row 1
        expect_spawn(0, 196, 106);
        ID_enemy_tiro[7] = 1'b1;
        step();
        check("spawn7_ativo", tiro_ativo, 4'b0001);
        step(1000);
        check("held_once", tiro_ativo, 4'b0001);
        ID_enemy_tiro[7] = 1'b0;
        step();

        expect_spawn(1, 236, 74);
        ID_enemy_tiro[3] = 1'b1;
        ID_enemy_tiro[9] = 1'b1;
        step();
        ID_enemy_tiro = '0;
        step();
        check("lowest_only", tiro_ativo, 4'b0011);
        check("no_count_multi", tiros_perdidos, 0);

        expect_spawn(2, 116, 138);
        pulse(10);
        expect_spawn(3, 276, 202);
        pulse(24);
        check("full", tiro_ativo, 4'b1111);
        pulse(0);
        check("drop1", tiros_perdidos, 1);
        for (int i = 0; i < 300; i++) pulse(0);
        check("drop_sat", tiros_perdidos, 255);
        check("sb_drain1", sb.size(), 0);

        ID_enemy_tiro[7] = 1'b1;
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("rs_ativo", tiro_ativo, 0);
        check("rs_vivo", jogador_vivo, 1);
        check("rs_perdidos", tiros_perdidos, 0);
        step(5);
        check("rs_no_fire", tiro_ativo, 0);
        ID_enemy_tiro[7] = 1'b0;
        step();
        expect_spawn(0, 196, 106);
        ID_enemy_tiro[7] = 1'b1;
        step();
        check("rs_refire", tiro_ativo, 4'b0001);
        ID_enemy_tiro[7] = 1'b0;
        step();

        enemy_vivos[5] = 1'b0;
        pulse(5);
        check("dead_ignored", tiro_ativo, 4'b0001);
        check("dead_no_count", tiros_perdidos, 0);
        enemy_vivos = '1;

        do_restart();
        formacao_y = 10'd448;
        expect_spawn(0, 116, 472);
        pulse(0);
        do_tick();
        check("move_y", 32'(tiro_y[9:0]), 476);
        check("move_ativo", tiro_ativo, 4'b0001);
        // Tick frees slot 0 while enemy 1 fires: new shot must land in slot 1, unmoved.
        expect_spawn(1, 156, 472);
        tick = 1'b1;
        ID_enemy_tiro[1] = 1'b1;
        step();
        tick = 1'b0;
        ID_enemy_tiro[1] = 1'b0;
        check("bottom_free", tiro_ativo, 4'b0010);
        check("same_cyc_y", 32'(tiro_y[19:10]), 472);
        step();
        do_tick();
        check("slot1_move", 32'(tiro_y[19:10]), 476);

        do_restart();
        formacao_x = 10'd180;
        formacao_y = 10'd412;
        player_x   = 10'd164;
        expect_spawn(0, 196, 436);
        pulse(0);
        formacao_x = 10'd140;
        expect_spawn(1, 196, 436);
        pulse(1);
        check("two_shots", tiro_ativo, 4'b0011);
        do_tick();
        check("edge_miss_hit", hit, 0);
        check("edge_miss_vivo", jogador_vivo, 1);
        check("edge_miss_y", 32'(tiro_y[9:0]), 440);
        player_x = 10'd180;
        do_tick();
        check("hit_pulse", hit, 1);
        check("hit_vivo", jogador_vivo, 0);
        check("hit_clear", tiro_ativo, 0);
        step();
        check("hit_one_cyc", hit, 0);
        check("morto_vivo", jogador_vivo, 0);
        pulse(2);
        check("morto_no_fire", tiro_ativo, 0);
        do_tick();
        check("morto_tick", tiro_ativo, 0);
        check("morto_no_hit", hit, 0);
        do_restart();
        check("revive", jogador_vivo, 1);
        check("sb_drain2", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
